// File: rtl/qif_pkg.sv
// qif_pkg: definitions shared by the QIF neuron and its synapses.
//   I_SYN_MAX / I_SYN_MIN : clamp limits of the 8-bit signed synaptic current
//   state_e               : synapse activity state
//   sat8()                : clamps a 10-bit signed value into -128..127
package qif_pkg;

    localparam int I_SYN_MAX = 127;
    localparam int I_SYN_MIN = -128;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        if (x > I_SYN_MAX) begin
            return 8'sh7f;
        end else if (x < I_SYN_MIN) begin
            return 8'sh80;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO with registered count/full/empty.
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   rdata        : head entry, valid whenever empty is low
//   count        : number of stored entries
//   full, empty  : registered status flags
module spike_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Explicit wrap keeps the pointers in range for any depth.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(Depth));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/qif_synapse.sv
// qif_synapse: synaptic current generator feeding the QIF neuron's I_syn.
// Weighted spikes are buffered, integrated one per cycle into a saturating
// 8-bit current, and the current decays exponentially toward zero.
//   clk          : clock
//   rst_n        : synchronous reset, ACTIVE-HIGH despite its name
//   spike_valid  : event offered
//   spike_weight : signed weight of the event
//   spike_ready  : event can be accepted (FIFO not full)
//   I_syn        : registered signed synaptic current
//   busy         : state is ACTIVE
//   sat_flag     : sticky, set whenever the clamp engaged
module qif_synapse
    import qif_pkg::*;
#(
    parameter int unsigned DECAY_SHIFT  = 3,
    parameter int unsigned DECAY_PERIOD = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spike_valid,
    input  logic signed [7:0] spike_weight,
    output logic              spike_ready,
    output logic signed [7:0] I_syn,
    output logic              busy,
    output logic              sat_flag
);

    localparam int unsigned TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] SMALL_LIM = 10'(1 << DECAY_SHIFT);

    state_e            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic signed [7:0] isyn_q, isyn_d;
    logic              sat_q;

    logic              accept, pop, tick;
    logic              fifo_full, fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic [7:0]        fifo_rdata;

    logic signed [9:0] x, dec, base, sum;
    logic [9:0]        abs_x;
    logic              clamp;

    assign spike_ready = !fifo_full;
    assign accept      = spike_valid && spike_ready;
    assign pop         = !fifo_empty;

    spike_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (accept),
        .wdata (spike_weight),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick = (state_q == ACTIVE) && (cnt_q == TW'(DECAY_PERIOD - 1));

    // Decay: small magnitudes step by one so the current always reaches zero
    // instead of stalling where the shift rounds to 0 (or -1 for negatives).
    always_comb begin
        x     = {{2{isyn_q[7]}}, isyn_q};
        abs_x = x[9] ? 10'(-x) : 10'(x);
        if (x == '0) begin
            dec = '0;
        end else if (abs_x < SMALL_LIM) begin
            dec = x[9] ? x + 10'sd1 : x - 10'sd1;
        end else begin
            dec = x - (x >>> DECAY_SHIFT);
        end
    end

    always_comb begin
        base   = tick ? dec : x;
        sum    = base + (pop ? {{2{fifo_rdata[7]}}, fifo_rdata} : 10'sd0);
        clamp  = (sum > I_SYN_MAX) || (sum < I_SYN_MIN);
        isyn_d = sat8(sum);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // FIFO drains this edge when it holds at most the entry being popped.
                if (!accept && isyn_d == '0 && fifo_count <= FCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Counter is zero in IDLE and restarts on entry to ACTIVE.
        if (state_q == ACTIVE && state_d == ACTIVE) begin
            cnt_d = tick ? '0 : cnt_q + TW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            isyn_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isyn_q  <= isyn_d;
            if (clamp) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign I_syn    = isyn_q;
    assign busy     = (state_q == ACTIVE);
    assign sat_flag = sat_q;

endmodule
